// File: rtl/rf_access_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rf_access_sequencer_pkg
//   Shared constants for the register-file access sequencer: default data and
//   address widths of the 32x32 dual-read register file, and the 3-bit state
//   encoding used by the sequencer FSM.
// ---------------------------------------------------------------------------
package rf_access_sequencer_pkg;

  // Default register file geometry: 32 registers of 32 bits.
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  // FSM state encoding.
  localparam int STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_RD      = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_WB = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_WR      = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_FIN     = 3'd4;

  // A request is in flight in every state except IDLE.
  function automatic logic is_busy_state(input logic [STATE_WIDTH-1:0] state);
    return state != ST_IDLE;
  endfunction

endpackage

// File: rtl/rf_wb_timer.sv
// ---------------------------------------------------------------------------
// rf_wb_timer
//   Counts the cycles spent waiting for a write-back value. The count is held
//   at zero while i_clear is high and advances while i_en is high. o_expire
//   flags the last permitted waiting cycle (count == WB_TIMEOUT-1).
//
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_clear   force the count back to zero (has priority over i_en)
//   i_en      advance the count by one
//   o_expire  count has reached WB_TIMEOUT-1
// ---------------------------------------------------------------------------
module rf_wb_timer #(
  parameter int WB_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_WIDTH = $clog2(WB_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(WB_TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] r_count;

  // The count stops at LAST_COUNT so it can never wrap back to zero if the
  // enable were to stay high past expiry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LAST_COUNT)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_expire = (r_count == LAST_COUNT);

endmodule

// File: rtl/rf_access_sequencer.sv
// ---------------------------------------------------------------------------
// rf_access_sequencer
//   Initiator side of the 32x32 dual-read register file interface. A START
//   request latches rs/rt/rd/wb_en, performs one READ cycle latching both
//   source operands, optionally waits for a write-back value (bounded by
//   WB_TIMEOUT cycles) and then issues one WRITE cycle. READ and WRITE are
//   decoded from mutually exclusive states so they are never high together.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   request pulse, accepted only in IDLE
//   i_rs, i_rt, i_rd          source 1, source 2 and destination addresses
//   i_wb_en                   request includes a write-back
//   i_wb_valid, i_wb_data     write-back handshake and value
//   i_rf_data_r1/_r2          register file read data
//   o_rf_read, o_rf_write     register file strobes
//   o_rf_addr_r1/_r2/_w       register file addresses (0 when strobe low)
//   o_rf_data_w               register file write data (0 when WRITE low)
//   o_op1, o_op2              latched operands
//   o_busy, o_done, o_err     in progress, completion pulse, sticky timeout
// ---------------------------------------------------------------------------
module rf_access_sequencer
  import rf_access_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH       = RF_ADDR_WIDTH,
  parameter int WB_TIMEOUT       = 16,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_rs,
  input  logic [ADDR_WIDTH-1:0] i_rt,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_wb_en,
  input  logic                  i_wb_valid,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [DATA_WIDTH-1:0] i_rf_data_r1,
  input  logic [DATA_WIDTH-1:0] i_rf_data_r2,
  output logic                  o_rf_read,
  output logic                  o_rf_write,
  output logic [ADDR_WIDTH-1:0] o_rf_addr_r1,
  output logic [ADDR_WIDTH-1:0] o_rf_addr_r2,
  output logic [ADDR_WIDTH-1:0] o_rf_addr_w,
  output logic [DATA_WIDTH-1:0] o_rf_data_w,
  output logic [DATA_WIDTH-1:0] o_op1,
  output logic [DATA_WIDTH-1:0] o_op2,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  logic [STATE_WIDTH-1:0] r_state;
  logic [STATE_WIDTH-1:0] w_next_state;

  logic [ADDR_WIDTH-1:0]  r_rs;
  logic [ADDR_WIDTH-1:0]  r_rt;
  logic [ADDR_WIDTH-1:0]  r_rd;
  logic                   r_wb_en;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_op1;
  logic [DATA_WIDTH-1:0]  r_op2;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_in_rd;
  logic                   w_in_wait;
  logic                   w_in_wr;
  logic                   w_skip_write;
  logic                   w_timer_expire;
  logic                   w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_in_rd   = (r_state == ST_RD);
  assign w_in_wait = (r_state == ST_WAIT_WB);
  assign w_in_wr   = (r_state == ST_WR);

  // Writes to r0 are dropped when protection is enabled; the request still
  // completes with a DONE pulse.
  assign w_skip_write = ZERO_REG_PROTECT && (r_rd == '0);

  // A valid write-back arriving on the expiry cycle takes precedence.
  assign w_timeout = w_in_wait && !i_wb_valid && w_timer_expire;

  // The timer restarts from zero on every entry into WAIT_WB.
  rf_wb_timer #(
    .WB_TIMEOUT (WB_TIMEOUT)
  ) u_wb_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!w_in_wait),
    .i_en     (w_in_wait),
    .o_expire (w_timer_expire)
  );

  // Next-state decode. RD and WR each last exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next_state = ST_RD;
      ST_RD:      w_next_state = r_wb_en ? ST_WAIT_WB : ST_FIN;
      ST_WAIT_WB: begin
        if (i_wb_valid) begin
          w_next_state = w_skip_write ? ST_FIN : ST_WR;
        end else if (w_timer_expire) begin
          w_next_state = ST_FIN;
        end
      end
      ST_WR:      w_next_state = ST_FIN;
      ST_FIN:     w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request fields are captured once per accepted START and held for the
  // whole request so input changes mid-request have no effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_wb_en <= 1'b0;
    end else if (w_accept) begin
      r_rs    <= i_rs;
      r_rt    <= i_rt;
      r_rd    <= i_rd;
      r_wb_en <= i_wb_en;
    end
  end

  // Operands are sampled at the edge that leaves RD and are held until the
  // next RD exit; the write-back value is captured only on WB_VALID.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_wdata <= '0;
    end else begin
      if (w_in_rd) begin
        r_op1 <= i_rf_data_r1;
        r_op2 <= i_rf_data_r2;
      end
      if (w_in_wait && i_wb_valid) begin
        r_wdata <= i_wb_data;
      end
    end
  end

  // ERR is sticky across IDLE and only cleared by the next accepted START.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  // Strobes decode straight from state; addresses and data are gated to 0
  // whenever their strobe is low.
  assign o_rf_read    = w_in_rd;
  assign o_rf_write   = w_in_wr;
  assign o_rf_addr_r1 = w_in_rd ? r_rs : '0;
  assign o_rf_addr_r2 = w_in_rd ? r_rt : '0;
  assign o_rf_addr_w  = w_in_wr ? r_rd : '0;
  assign o_rf_data_w  = w_in_wr ? r_wdata : '0;
  assign o_op1        = r_op1;
  assign o_op2        = r_op2;
  assign o_busy       = is_busy_state(r_state);
  assign o_done       = (r_state == ST_FIN);
  assign o_err        = r_err;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_access_sequencer
//   Drives requests into rf_access_sequencer against a behavioural register
//   file. Each request pushes its expected operands, write and error outcome
//   into a queue; a monitor pops and compares it on every DONE pulse.
// ---------------------------------------------------------------------------
module tb_rf_access_sequencer;

  localparam int WB_TIMEOUT = 16;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        wrote;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic        err;
  } expect_t;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        wbEn;
  logic        wbValid;
  logic [31:0] wbData;
  logic [31:0] rfDataR1;
  logic [31:0] rfDataR2;
  logic        rfRead;
  logic        rfWrite;
  logic [4:0]  rfAddrR1;
  logic [4:0]  rfAddrR2;
  logic [4:0]  rfAddrW;
  logic [31:0] rfDataW;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] rfMem [32];
  logic [31:0] refRegs [32];
  logic        preloadEn;
  logic [4:0]  preloadAddr;
  logic [31:0] preloadData;

  expect_t     sbQueue [$];
  int          checkCount = 0;
  int          failCount  = 0;
  int          readCount  = 0;
  int          writeCount = 0;
  logic        curWrote;
  logic [4:0]  curWAddr;
  logic [31:0] curWData;

  rf_access_sequencer #(
    .DATA_WIDTH       (32),
    .ADDR_WIDTH       (5),
    .WB_TIMEOUT       (WB_TIMEOUT),
    .ZERO_REG_PROTECT (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_rs         (rs),
    .i_rt         (rt),
    .i_rd         (rd),
    .i_wb_en      (wbEn),
    .i_wb_valid   (wbValid),
    .i_wb_data    (wbData),
    .i_rf_data_r1 (rfDataR1),
    .i_rf_data_r2 (rfDataR2),
    .o_rf_read    (rfRead),
    .o_rf_write   (rfWrite),
    .o_rf_addr_r1 (rfAddrR1),
    .o_rf_addr_r2 (rfAddrR2),
    .o_rf_addr_w  (rfAddrW),
    .o_rf_data_w  (rfDataW),
    .o_op1        (op1),
    .o_op2        (op2),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: asynchronous dual read, write on rising edge.
  assign rfDataR1 = rfMem[rfAddrR1];
  assign rfDataR2 = rfMem[rfAddrR2];

  always @(posedge clk) begin
    if (preloadEn) begin
      rfMem[preloadAddr] <= preloadData;
    end else if (rfWrite) begin
      rfMem[rfAddrW] <= rfDataW;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Monitor on the falling edge: strobe exclusivity every cycle, write
  // capture, and scoreboard comparison on each DONE pulse.
  always @(negedge clk) begin
    if (!rstN) begin
      curWrote = 1'b0;
      curWAddr = '0;
      curWData = '0;
    end else begin
      checkOutput("rdwrExclusive", {31'd0, rfRead & rfWrite}, 32'd0);
      if (rfRead) readCount++;
      if (rfWrite) begin
        writeCount++;
        curWrote = 1'b1;
        curWAddr = rfAddrW;
        curWData = rfDataW;
      end
      if (done) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sbUnexpectedDone", 32'd1, 32'd0);
        end else begin
          expect_t e;
          e = sbQueue.pop_front();
          checkOutput("sbOp1", op1, e.op1);
          checkOutput("sbOp2", op2, e.op2);
          checkOutput("sbWrote", {31'd0, curWrote}, {31'd0, e.wrote});
          if (e.wrote) begin
            checkOutput("sbWAddr", {27'd0, curWAddr}, {27'd0, e.wAddr});
            checkOutput("sbWData", curWData, e.wData);
          end
          checkOutput("sbErr", {31'd0, err}, {31'd0, e.err});
        end
        curWrote = 1'b0;
      end
    end
  end

  assert property (@(negedge clk) !(rfRead && rfWrite));

  task automatic preloadAll();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      preloadEn   = 1'b1;
      preloadAddr = 5'(i);
      case (i)
        0:       preloadData = 32'h0000_0000;
        3:       preloadData = 32'h0000_00AA;
        7:       preloadData = 32'h1234_5678;
        default: preloadData = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
      endcase
      refRegs[i] = preloadData;
    end
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  // Presents one request to the DUT for exactly one rising edge.
  task automatic startReq(input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic we);
    @(negedge clk);
    rs    = s1;
    rt    = s2;
    rd    = d;
    wbEn  = we;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("returnIdle", {31'd0, busy}, 32'd0);
  endtask

  // Full request: predicts the outcome, drives it, checks cycle timing.
  // validDelay is the WAIT_WB cycle index carrying WB_VALID, -1 for never.
  task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic we,
                               input int validDelay, input logic [31:0] data);
    expect_t e;
    int      cnt;
    e.op1   = refRegs[s1];
    e.op2   = refRegs[s2];
    e.wrote = 1'b0;
    e.wAddr = d;
    e.wData = data;
    e.err   = 1'b0;
    if (we) begin
      if (validDelay >= 0 && validDelay < WB_TIMEOUT) begin
        if (d != 5'd0) begin
          e.wrote    = 1'b1;
          refRegs[d] = data;
        end
      end else begin
        e.err = 1'b1;
      end
    end
    sbQueue.push_back(e);

    startReq(s1, s2, d, we);
    @(negedge clk);
    checkOutput("rdStrobe", {31'd0, rfRead}, 32'd1);
    checkOutput("rdAddrR1", {27'd0, rfAddrR1}, {27'd0, s1});
    checkOutput("rdAddrR2", {27'd0, rfAddrR2}, {27'd0, s2});
    checkOutput("rdAddrWIdle", {27'd0, rfAddrW}, 32'd0);
    checkOutput("rdBusy", {31'd0, busy}, 32'd1);
    checkOutput("errClearOnStart", {31'd0, err}, 32'd0);

    if (!we) begin
      @(negedge clk);
      checkOutput("doneLatencyNoWb", {31'd0, done}, 32'd1);
    end else if (validDelay >= 0) begin
      for (int k = 0; k <= validDelay; k++) begin
        @(negedge clk);
        wbValid = (k == validDelay);
        wbData  = (k == validDelay) ? data : $urandom;
      end
      @(negedge clk);
      wbValid = 1'b0;
      if (d == 5'd0) begin
        checkOutput("zeroRegNoWrite", {31'd0, rfWrite}, 32'd0);
        checkOutput("zeroRegDone", {31'd0, done}, 32'd1);
      end else begin
        checkOutput("wrStrobe", {31'd0, rfWrite}, 32'd1);
        checkOutput("wrAddr", {27'd0, rfAddrW}, {27'd0, d});
        checkOutput("wrData", rfDataW, data);
        checkOutput("wrReadLow", {31'd0, rfRead}, 32'd0);
        @(negedge clk);
        checkOutput("doneAfterWr", {31'd0, done}, 32'd1);
      end
    end else begin
      cnt = 0;
      while (cnt < 60) begin
        @(negedge clk);
        if (done) break;
        cnt++;
      end
      checkOutput("wbTimeoutCycles", 32'(cnt), 32'(WB_TIMEOUT));
    end
    waitIdle();
  endtask

  initial begin
    int reads0;
    int writes0;
    start       = 1'b0;
    rs          = '0;
    rt          = '0;
    rd          = '0;
    wbEn        = 1'b0;
    wbValid     = 1'b0;
    wbData      = '0;
    preloadEn   = 1'b0;
    preloadAddr = '0;
    preloadData = '0;
    rstN        = 1'b0;

    preloadAll();
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetErr", {31'd0, err}, 32'd0);
    checkOutput("resetOp1", op1, 32'd0);
    checkOutput("resetStrobes", {30'd0, rfRead, rfWrite}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] reset in the middle of WAIT_WB");
    writes0 = writeCount;
    startReq(5'd1, 5'd2, 5'd5, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("midResetOps", op1 | op2, 32'd0);
    checkOutput("midResetFlags", {29'd0, rfRead, rfWrite, done}, 32'd0);
    checkOutput("midResetAddr", {22'd0, rfAddrW, rfAddrR1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("midResetNoWrite", 32'(writeCount - writes0), 32'd0);
    checkOutput("midResetIdle", {31'd0, busy}, 32'd0);

    $display("[TB] read only: r3 and r7");
    applyStimulus(5'd3, 5'd7, 5'd0, 1'b0, 0, 32'd0);

    $display("[TB] write-back to r9, then read r9");
    applyStimulus(5'd1, 5'd2, 5'd9, 1'b1, 2, 32'hDEAD_BEEF);
    applyStimulus(5'd9, 5'd9, 5'd0, 1'b0, 0, 32'd0);

    $display("[TB] write-back to r0 is suppressed");
    applyStimulus(5'd4, 5'd5, 5'd0, 1'b1, 0, 32'hFFFF_FFFF);
    applyStimulus(5'd0, 5'd3, 5'd0, 1'b0, 0, 32'd0);

    $display("[TB] write-back timeout");
    applyStimulus(5'd6, 5'd8, 5'd10, 1'b1, -1, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("errStickyIdle", {31'd0, err}, 32'd1);
    applyStimulus(5'd10, 5'd11, 5'd12, 1'b1, WB_TIMEOUT - 1, 32'hCAFE_0001);

    $display("[TB] source equals destination reads old value");
    applyStimulus(5'd4, 5'd4, 5'd4, 1'b1, 0, 32'h5555_AAAA);
    applyStimulus(5'd4, 5'd12, 5'd0, 1'b0, 0, 32'd0);

    $display("[TB] START held high for 20 cycles");
    reads0  = readCount;
    writes0 = writeCount;
    for (int i = 0; i < 7; i++) begin
      expect_t e;
      e.op1   = refRegs[3];
      e.op2   = refRegs[7];
      e.wrote = 1'b0;
      e.wAddr = '0;
      e.wData = '0;
      e.err   = 1'b0;
      sbQueue.push_back(e);
    end
    @(negedge clk);
    rs    = 5'd3;
    rt    = 5'd7;
    rd    = 5'd13;
    wbEn  = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      wbValid = 1'($urandom_range(0, 1));
      wbData  = $urandom;
    end
    start   = 1'b0;
    wbValid = 1'b0;
    @(negedge clk);
    waitIdle();
    checkOutput("heldStartReads", 32'(readCount - reads0), 32'd7);
    checkOutput("heldStartNoWrite", 32'(writeCount - writes0), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

  // Absolute time limit so a stuck clock or wait can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rf_access_sequencer.md
Name: rf_access_sequencer

Overview:
- Initiator side of the 32x32 dual-read register file interface.
- Takes decoded operand/destination fields (rs, rt, rd) from the control unit and sequences one READ cycle, latching both source operands.
- Optionally waits for a write-back value, then issues one WRITE cycle.
- Guarantees READ and WRITE are never asserted together, so the register file never drives X.

Parameters:
DATA_WIDTH, 32, width of register data (matches `DATA_WIDTH).
ADDR_WIDTH, 5, register address width (matches `REG_ADDR_INDEX_LIMIT+1).
WB_TIMEOUT, 16, max cycles spent in WAIT_WB before abort (>=2).
ZERO_REG_PROTECT, 1, when 1 a write to rd=0 is suppressed.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous reset, active-low
START  in  1  request pulse; accepted only in IDLE
RS  in  ADDR_WIDTH  source register 1 address
RT  in  ADDR_WIDTH  source register 2 address
RD  in  ADDR_WIDTH  destination register address
WB_EN  in  1  request includes a write-back
WB_VALID  in  1  write-back data present on WB_DATA this cycle
WB_DATA  in  DATA_WIDTH  write-back value
RF_DATA_R1  in  DATA_WIDTH  register file read port 1
RF_DATA_R2  in  DATA_WIDTH  register file read port 2
RF_READ  out  1  register file READ
RF_WRITE  out  1  register file WRITE
RF_ADDR_R1  out  ADDR_WIDTH  register file ADDR_R1
RF_ADDR_R2  out  ADDR_WIDTH  register file ADDR_R2
RF_ADDR_W  out  ADDR_WIDTH  register file ADDR_W
RF_DATA_W  out  DATA_WIDTH  register file DATA_W
OP1  out  DATA_WIDTH  latched operand 1
OP2  out  DATA_WIDTH  latched operand 2
BUSY  out  1  request in progress
DONE  out  1  one-cycle completion pulse
ERR  out  1  sticky write-back timeout flag

Behaviour:
Reset:
- RST=0 forces state IDLE immediately, regardless of clock.
- All outputs 0; internal rs_q/rt_q/rd_q/wb_en_q/wdata_q/timer cleared.
- Reset mid-request aborts it: no WRITE is issued, DONE is not pulsed.

States: IDLE, RD, WAIT_WB, WR, FIN.

IDLE:
- START=1 latches RS/RT/RD/WB_EN, clears ERR, next state RD.
- START is ignored in all other states.

RD (exactly one cycle):
- RF_READ=1; RF_ADDR_R1=rs_q; RF_ADDR_R2=rt_q.
- At the exiting edge: OP1<=RF_DATA_R1, OP2<=RF_DATA_R2.
- Next state: WAIT_WB if wb_en_q, else FIN.

WAIT_WB:
- RF_READ=0, RF_WRITE=0; timer increments each cycle.
- WB_VALID=1: wdata_q<=WB_DATA. Next state FIN if (ZERO_REG_PROTECT and rd_q==0), else WR.
- Timer reaches WB_TIMEOUT-1 with WB_VALID=0: ERR<=1, next state FIN, no write.
- WB_VALID on the same cycle the timeout would expire: valid wins, no ERR.

WR (exactly one cycle):
- RF_WRITE=1; RF_ADDR_W=rd_q; RF_DATA_W=wdata_q. The register file loads on this cycle's rising edge.
- Next state FIN.

FIN:
- DONE=1 for one cycle, then IDLE.

Outputs:
- BUSY=1 in RD, WAIT_WB, WR, FIN; 0 in IDLE.
- RF_ADDR_*/RF_DATA_W are 0 whenever their strobe is low.
- OP1/OP2 hold their values until the next RD exit.
- ERR holds until the next accepted START.

Invariant: RF_READ & RF_WRITE == 0 in every cycle.

Latency (START seen at edge t):
- RD at t+1; DONE at t+2 with no write-back.
- Write-back with WB_VALID in the first WAIT_WB cycle: WR at t+3, DONE at t+4.

rs/rt equal to rd: reads return the pre-write value (no forwarding).

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH constants and state encoding localparams (IDLE=0, RD=1, WAIT_WB=2, WR=3, FIN=4, 3-bit).
- One natural sub-module: rf_wb_timer (load/clear, count-enable, expire flag, width $clog2(WB_TIMEOUT)).
- The FSM and datapath latches stay in the top module.

Test Plan:
1. Reset mid-WAIT_WB (RST low between edges) -> all outputs 0 immediately, no RF_WRITE, state IDLE; next START works normally.
2. Preload r3=0x0000_00AA, r7=0x1234_5678; START RS=3 RT=7 WB_EN=0 -> RF_READ one cycle at t+1; OP1=0xAA, OP2=0x12345678 at t+2; DONE at t+2; RF_WRITE never high.
3. START RS=1 RT=2 RD=9 WB_EN=1; WB_VALID with 0xDEAD_BEEF three cycles later -> one RF_WRITE cycle with ADDR_W=9, DATA_W=0xDEADBEEF; subsequent read of r9 returns 0xDEADBEEF; DONE one cycle after WR.
4. RD=0, WB_EN=1, ZERO_REG_PROTECT=1, WB_VALID data 0xFFFF_FFFF -> no RF_WRITE; DONE asserted; r0 unchanged.
5. WB_EN=1, WB_VALID never asserted, WB_TIMEOUT=16 -> ERR=1 after 16 WAIT_WB cycles, DONE pulse, no write; ERR clears on next START.
6. START held high continuously for 20 cycles plus random WB_VALID -> only one request per IDLE visit; assertion checks RF_READ & RF_WRITE never both 1 across the run.
